// File: rtl/bcd_store_seq.sv
// bcd_store_seq: FX33 sequencer. Latches VX and I, converts VX to three BCD
// digits, then writes hundreds/tens/ones to I, I+1, I+2 over a req/gnt port.
module bcd_store_seq #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        value,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_gnt
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CONV = 3'd1;
   localparam logic [2:0] WR_H = 3'd2;
   localparam logic [2:0] WR_T = 3'd3;
   localparam logic [2:0] WR_O = 3'd4;
   localparam logic [2:0] DONE = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [7:0]        value_q;
   logic [ADDR_W-1:0] base_q;
   logic [3:0]        hund_q, tens_q, ones_q;
   logic [11:0]       conv_bcd;
   logic              accept;

   // start is honoured only from IDLE; anything arriving while busy is dropped
   assign accept = (state_q == IDLE) && start;

   // Combinational binary-to-BCD converter (double dabble) on the latched value
   always_comb begin
      logic [19:0] dd;
      dd = {12'd0, value_q};
      for (int i = 0; i < 8; i++) begin
         if (dd[11:8] >= 4'd5)  dd[11:8]  = dd[11:8]  + 4'd3;
         if (dd[15:12] >= 4'd5) dd[15:12] = dd[15:12] + 4'd3;
         if (dd[19:16] >= 4'd5) dd[19:16] = dd[19:16] + 4'd3;
         dd = dd << 1;
      end
      conv_bcd = dd[19:8];
   end

   // Next-state logic; each write state holds until the arbiter grants it
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CONV;
         CONV:    state_d = WR_H;
         WR_H:    if (mem_gnt) state_d = WR_T;
         WR_T:    if (mem_gnt) state_d = WR_O;
         WR_O:    if (mem_gnt) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any pending write immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand latch: captured only on an accepted start so later starts cannot disturb them
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= 8'd0;
         base_q  <= '0;
      end else if (accept) begin
         value_q <= value;
         base_q  <= base_addr;
      end
   end

   // Digit registers, loaded during the single CONV cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         hund_q <= 4'd0;
         tens_q <= 4'd0;
         ones_q <= 4'd0;
      end else if (state_q == CONV) begin
         hund_q <= conv_bcd[11:8];
         tens_q <= conv_bcd[7:4];
         ones_q <= conv_bcd[3:0];
      end
   end

   // Outputs decoded purely from registers; no combinational path from mem_gnt.
   // Address wraps naturally at ADDR_W bits.
   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      mem_req   = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'd0;
      unique case (state_q)
         WR_H: begin
            mem_req   = 1'b1;
            mem_addr  = base_q;
            mem_wdata = {4'b0000, hund_q};
         end
         WR_T: begin
            mem_req   = 1'b1;
            mem_addr  = base_q + ADDR_W'(1);
            mem_wdata = {4'b0000, tens_q};
         end
         WR_O: begin
            mem_req   = 1'b1;
            mem_addr  = base_q + ADDR_W'(2);
            mem_wdata = {4'b0000, ones_q};
         end
         default: begin
            mem_req   = 1'b0;
            mem_addr  = '0;
            mem_wdata = 8'd0;
         end
      endcase
   end

endmodule
